// File: rtl/mmio_pkg.sv
// Shared constants for the SLC-3 memory / memory-mapped-I/O controller.
package mmio_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SRAM_ACC = 2'd1;
    localparam logic [1:0] ST_DONE     = 2'd2;

    // Word offsets inside the 16-word I/O window
    localparam int unsigned OFF_SW  = 0;
    localparam int unsigned OFF_LED = 1;
    localparam int unsigned OFF_HEX = 2;

    // Number of data words needed to hold num_hex 4-bit digits
    function automatic int unsigned hex_words(input int unsigned num_hex,
                                              input int unsigned data_w);
        return (4 * num_hex + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/mmio_if.sv
// CPU-side request/ready bus (MAR/MDR view) between the SLC-3 core and the controller.
interface mmio_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (output req, output we, output addr, output wdata,
                    input rdata, input ready);
    modport slave  (input req, input we, input addr, input wdata,
                    output rdata, output ready);
endinterface

// File: rtl/mmio_regfile.sv
// I/O register block: switch synchroniser, LED register, hex-digit registers, read mux.
module mmio_regfile
    import mmio_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned SW_W    = 10,
    parameter int unsigned LED_W   = 10,
    parameter int unsigned NUM_HEX = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [ADDR_W-1:0]    off,
    input  logic                 wr_en,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [SW_W-1:0]      sw,
    output logic [DATA_W-1:0]    rd_data_c,
    output logic [LED_W-1:0]     led,
    output logic [4*NUM_HEX-1:0] hex_digits
);
    localparam int unsigned HEX_WORDS = hex_words(NUM_HEX, DATA_W);
    localparam int unsigned HEX_BITS  = 4 * NUM_HEX;
    localparam int unsigned HEX_PAD   = HEX_WORDS * DATA_W;

    logic [SW_W-1:0]     sw_meta;
    logic [SW_W-1:0]     sw_sync;
    logic [LED_W-1:0]    led_nxt;
    logic [HEX_BITS-1:0] hex_q;
    logic [HEX_BITS-1:0] hex_nxt;
    logic [HEX_PAD-1:0]  hex_wide;
    logic [HEX_PAD-1:0]  hex_wr;

    assign hex_wide   = HEX_PAD'(hex_q);
    assign hex_digits = hex_q;

    // Two-flop synchroniser for the asynchronous board switches
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    // Write decode; digits beyond NUM_HEX in the last word are dropped
    always_comb begin
        led_nxt = led;
        hex_wr  = hex_wide;
        if (wr_en) begin
            if (off == ADDR_W'(OFF_LED)) begin
                led_nxt = wdata[LED_W-1:0];
            end
            for (int k = 0; k < HEX_WORDS; k++) begin
                if (off == ADDR_W'(OFF_HEX + k)) begin
                    hex_wr[k*DATA_W +: DATA_W] = wdata;
                end
            end
        end
        hex_nxt = hex_wr[HEX_BITS-1:0];
    end

    // LED and hex registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            led   <= '0;
            hex_q <= '0;
        end else begin
            led   <= led_nxt;
            hex_q <= hex_nxt;
        end
    end

    // Read mux; unmapped offsets read as zero
    always_comb begin
        rd_data_c = '0;
        if (off == ADDR_W'(OFF_SW)) begin
            rd_data_c = DATA_W'(sw_sync);
        end
        if (off == ADDR_W'(OFF_LED)) begin
            rd_data_c = DATA_W'(led);
        end
        for (int k = 0; k < HEX_WORDS; k++) begin
            if (off == ADDR_W'(OFF_HEX + k)) begin
                rd_data_c = hex_wide[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/mmio_controller.sv
// SLC-3 memory / memory-mapped-I/O controller: SRAM with wait states plus I/O window.
module mmio_controller
    import mmio_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned SW_W      = 10,
    parameter int unsigned LED_W     = 10,
    parameter int unsigned NUM_HEX   = 4,
    parameter int unsigned SRAM_WAIT = 1,
    parameter int unsigned IO_BASE   = 32'hFFF0
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    mmio_if.slave                bus,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic [DATA_W-1:0]    sram_wdata,
    input  logic [DATA_W-1:0]    sram_rdata,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    input  logic [SW_W-1:0]      sw,
    output logic [LED_W-1:0]     led,
    output logic [4*NUM_HEX-1:0] hex_digits
);
    localparam int unsigned CNT_W = 4;

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              we_lat, we_lat_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic [DATA_W-1:0] rdata_q, rdata_nxt;
    logic              ready_q, ready_nxt;
    logic              oe_n_nxt, we_n_nxt;
    logic              is_io_c;
    logic [ADDR_W-1:0] io_off_c;
    logic [DATA_W-1:0] io_rdata_c;
    logic              reg_wr_c;

    assign is_io_c   = bus.addr >= ADDR_W'(IO_BASE);
    assign io_off_c  = bus.addr - ADDR_W'(IO_BASE);
    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;

    mmio_regfile #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .SW_W    (SW_W),
        .LED_W   (LED_W),
        .NUM_HEX (NUM_HEX)
    ) u_regfile (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .off        (io_off_c),
        .wr_en      (reg_wr_c),
        .wdata      (bus.wdata),
        .sw         (sw),
        .rd_data_c  (io_rdata_c),
        .led        (led),
        .hex_digits (hex_digits)
    );

    // State and registered outputs; reset aborts any access and drops strobes at once
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            we_lat     <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            we_lat     <= we_lat_nxt;
            sram_addr  <= addr_nxt;
            sram_wdata <= wdata_nxt;
            rdata_q    <= rdata_nxt;
            ready_q    <= ready_nxt;
            sram_oe_n  <= oe_n_nxt;
            sram_we_n  <= we_n_nxt;
        end
    end

    // Next state; strobes are computed for the cycle after the edge so they stay registered
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        we_lat_nxt = we_lat;
        addr_nxt   = sram_addr;
        wdata_nxt  = sram_wdata;
        rdata_nxt  = rdata_q;
        ready_nxt  = 1'b0;
        oe_n_nxt   = 1'b1;
        we_n_nxt   = 1'b1;
        reg_wr_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req) begin
                    if (is_io_c) begin
                        state_nxt = ST_DONE;
                        ready_nxt = 1'b1;
                        reg_wr_c  = bus.we;
                        rdata_nxt = bus.we ? '0 : io_rdata_c;
                    end else begin
                        state_nxt  = ST_SRAM_ACC;
                        cnt_nxt    = CNT_W'(SRAM_WAIT);
                        we_lat_nxt = bus.we;
                        addr_nxt   = bus.addr;
                        wdata_nxt  = bus.wdata;
                        oe_n_nxt   = bus.we;
                        we_n_nxt   = ~bus.we;
                    end
                end
            end
            ST_SRAM_ACC: begin
                if (cnt != '0) begin
                    cnt_nxt  = cnt - CNT_W'(1);
                    oe_n_nxt = we_lat;
                    we_n_nxt = ~we_lat;
                end else begin
                    state_nxt = ST_DONE;
                    ready_nxt = 1'b1;
                    rdata_nxt = we_lat ? '0 : sram_rdata;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
